// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   hz_state_e : sequencer state (RUN, LU_STALL, MEM_WAIT)
//   REG_ZERO   : architectural x0, never a real producer of a value
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use comparator. Flags when the instruction in
//   ID reads a register that the load currently in EX is about to write.
//   Ports:
//     id_rs1, id_rs2         : source registers of the ID instruction
//     id_use_rs1, id_use_rs2 : ID instruction actually reads that source
//     ex_rd                  : destination of the EX instruction
//     ex_memread             : EX instruction is a load
//     lu_hit                 : load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       lu_hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // A load to x0 writes nothing, so a consumer of x0 never has to wait.
  assign lu_hit = ex_memread && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 core. Each cycle it
//   decides whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold, take a
//   bubble or flush. Event priority: DM freeze > redirect > load-use > fetch
//   wait. Control outputs are combinational (same-cycle effect); only the
//   state, the two internal counters, stall_cycles and timeout_err are
//   registered.
//   Parameters:
//     LU_PENALTY   : bubble cycles per load-use hazard (1..3)
//     WAIT_TIMEOUT : frozen DM cycles tolerated before timeout_err (1..65535)
//   Ports:
//     clk, rst                       : clock, synchronous active-high reset
//     id_rs1/id_rs2/id_use_rs1/2     : ID-stage source operands
//     ex_rd/ex_memread/ex_redirect   : EX-stage destination, load, redirect
//     im_busy                        : no valid fetch this cycle
//     dm_req/dm_ack                  : data-memory handshake in MEM
//     pc_hold, ifid_hold, ifid_flush : PC and IF/ID control
//     idex_hold/bubble/flush         : ID/EX NOP, selMuxNop and flush inputs
//     exmem_hold, memwb_bubble       : later-stage control during a freeze
//     timeout_err                    : sticky DM wait timeout
//     stall_cycles                   : count of cycles with pc_hold=1
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LU_PENALTY   = 1,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        im_busy,
  input  logic        dm_req,
  input  logic        dm_ack,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_hold,
  output logic        idex_bubble,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);

  localparam logic [16:0] WAIT_LIMIT = 17'(WAIT_TIMEOUT);
  localparam logic [1:0]  LU_RELOAD  = 2'(LU_PENALTY - 1);

  hz_state_e   state;
  logic [1:0]  lu_cnt;
  logic [15:0] wait_cnt;
  logic [16:0] wait_inc;

  logic lu_hit;
  logic in_lu;
  logic freeze;
  logic redirect;
  logic lu_stall;
  logic fetch_wait;
  logic active;

  hazard_detect u_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .lu_hit     (lu_hit)
  );

  // Event decode in priority order; each event masks all lower ones, which
  // keeps hold, flush and bubble mutually exclusive per register.
  // Once timeout_err is set the freeze is permanently disabled so a dead DM
  // cannot lock up the core.
  assign in_lu      = (state == LU_STALL);
  assign freeze     = dm_req && !dm_ack && !timeout_err;
  assign redirect   = ex_redirect && !freeze;
  // Outside LU_STALL (including the cycle a freeze releases) a fresh
  // comparator hit starts a new penalty; inside LU_STALL the stall simply
  // continues until its count expires.
  assign lu_stall   = !freeze && !redirect && (in_lu || lu_hit);
  assign fetch_wait = !freeze && !redirect && !lu_stall && im_busy;
  assign active     = !rst;

  assign pc_hold      = active && (freeze || lu_stall || fetch_wait);
  assign ifid_hold    = active && (freeze || lu_stall);
  assign ifid_flush   = active && (redirect || fetch_wait);
  assign idex_hold    = active && freeze;
  assign idex_bubble  = active && lu_stall;
  assign idex_flush   = active && redirect;
  assign exmem_hold   = active && freeze;
  assign memwb_bubble = active && freeze;

  assign wait_inc = {1'b0, wait_cnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      lu_cnt       <= 2'd0;
      wait_cnt     <= 16'd0;
      stall_cycles <= 32'd0;
      timeout_err  <= 1'b0;
    end else begin
      if (pc_hold) begin
        stall_cycles <= stall_cycles + 32'd1;
      end

      if (freeze) begin
        // Any pending load-use penalty is dropped: the load is still held in
        // EX and the hazard is re-detected once the freeze releases.
        lu_cnt <= 2'd0;
        if (wait_inc == WAIT_LIMIT) begin
          timeout_err <= 1'b1;
          wait_cnt    <= 16'd0;
          state       <= RUN;
        end else begin
          wait_cnt <= wait_inc[15:0];
          state    <= MEM_WAIT;
        end
      end else begin
        wait_cnt <= 16'd0;
        if (redirect) begin
          state  <= RUN;
          lu_cnt <= 2'd0;
        end else if (lu_stall && in_lu) begin
          if (lu_cnt == 2'd1) begin
            state  <= RUN;
            lu_cnt <= 2'd0;
          end else begin
            lu_cnt <= lu_cnt - 2'd1;
          end
        end else if (lu_stall && (LU_RELOAD != 2'd0)) begin
          state  <= LU_STALL;
          lu_cnt <= LU_RELOAD;
        end else begin
          state  <= RUN;
          lu_cnt <= 2'd0;
        end
      end
    end
  end

endmodule
